// File: rtl/alu_pkg.sv
// Shared opcode encodings, widths and operand bundle for the 64-bit alu and its issue front end.
package alu_pkg;

   localparam int ALU_W = 64;
   localparam int OPC_W = 2;

   localparam logic [OPC_W-1:0] ALU_ADD = 2'b00;
   localparam logic [OPC_W-1:0] ALU_SUB = 2'b01;
   localparam logic [OPC_W-1:0] ALU_AND = 2'b10;
   localparam logic [OPC_W-1:0] ALU_XOR = 2'b11;

   // Request fields other than the tag, whose width is set per instance.
   localparam int REQ_W = OPC_W + 2 * ALU_W;
   localparam int RSP_W = ALU_W + 1;

   typedef logic [ALU_W-1:0] alu_word_t;

   typedef struct packed {
      logic [OPC_W-1:0] opcode;
      alu_word_t        a;
      alu_word_t        b;
   } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 64-bit alu: ADD, SUB, AND, XOR with a signed-overflow flag for ADD/SUB.
module alu
   import alu_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   input  logic [ALU_W-1:0] in1,
   input  logic [ALU_W-1:0] in2,
   output logic [ALU_W-1:0] out,
   output logic             of_flag
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      out     = '0;
      of_flag = 1'b0;
      case (opcode)
         ALU_ADD: begin
            out     = in1 + in2;
            of_flag = (in1[ALU_W-1] == in2[ALU_W-1]) && (out[ALU_W-1] != in1[ALU_W-1]);
         end
         ALU_SUB: begin
            out     = in1 - in2;
            of_flag = (in1[ALU_W-1] != in2[ALU_W-1]) && (out[ALU_W-1] != in1[ALU_W-1]);
         end
         ALU_AND: out = in1 & in2;
         ALU_XOR: out = in1 ^ in2;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/alu_issue.sv
// Two-stage valid/ready issue wrapper around the alu (S1 operands, S2 result).
// Optional condition-code registers are built when ALU_ISSUE_CC_EN is defined.
module alu_issue
   import alu_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [OPC_W-1:0] req_opcode,
   input  logic [ALU_W-1:0] req_a,
   input  logic [ALU_W-1:0] req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [ALU_W-1:0] rsp_result,
   output logic             rsp_of,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [CNT_W-1:0] op_count,
   output logic             cc_zf,
   output logic             cc_sf,
   output logic             cc_of
);

   alu_req_t         s1_req;
   logic [TAG_W-1:0] s1_tag;
   logic             s1_valid;
   logic             s2_valid;
   logic [ALU_W-1:0] alu_out;
   logic             alu_of;
   logic             req_fire;
   logic             rsp_fire;
   logic             s2_adv;

   // S1 may drain into S2 whenever S2 is empty or is being consumed this cycle.
   assign s2_adv    = s1_valid & (~s2_valid | rsp_ready);
   assign req_ready = ~s1_valid | s2_adv;
   assign req_fire  = req_valid & req_ready;
   assign rsp_fire  = s2_valid & rsp_ready;
   assign rsp_valid = s2_valid;

   // S1 valid bit
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all registers sample pre-edge values.
      if (reset) begin
         s1_valid <= 1'b0;
      end else if (req_fire) begin
         s1_valid <= 1'b1;
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // NOTE: the S1 payload has no reset; it is only observed through s1_valid, which is reset.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         s1_req.opcode <= req_opcode;
         s1_req.a      <= req_a;
         s1_req.b      <= req_b;
         s1_tag        <= req_tag;
      end
   end

   alu u_alu (
      .opcode  (s1_req.opcode),
      .in1     (s1_req.a),
      .in2     (s1_req.b),
      .out     (alu_out),
      .of_flag (alu_of)
   );

   // S2 holds the result visible on the response port until it is taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid   <= 1'b0;
         rsp_result <= '0;
         rsp_of     <= 1'b0;
         rsp_tag    <= '0;
      end else if (s2_adv) begin
         s2_valid   <= 1'b1;
         rsp_result <= alu_out;
         rsp_of     <= alu_of;
         rsp_tag    <= s1_tag;
      end else if (rsp_fire) begin
         s2_valid   <= 1'b0;
      end
   end

   // Completed-operation counter saturates rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_count <= '0;
      end else if (rsp_fire && (op_count != {CNT_W{1'b1}})) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

`ifdef ALU_ISSUE_CC_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cc_zf <= 1'b0;
         cc_sf <= 1'b0;
         cc_of <= 1'b0;
      end else if (rsp_fire) begin
         cc_zf <= (rsp_result == '0);
         cc_sf <= rsp_result[ALU_W-1];
         cc_of <= rsp_of;
      end
   end
`else
   assign cc_zf = 1'b0;
   assign cc_sf = 1'b0;
   assign cc_of = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed and scoreboarded bench for alu_issue: vector table, reset, backpressure, random stream.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_opcode = 2'b00;
   logic [63:0] req_a = '0;
   logic [63:0] req_b = '0;
   logic [3:0]  req_tag = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_result;
   logic        rsp_of;
   logic [3:0]  rsp_tag;
   logic [31:0] op_count;
   logic        cc_zf;
   logic        cc_sf;
   logic        cc_of;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_issue #(.TAG_W(4), .CNT_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_tag    (req_tag),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_of     (rsp_of),
      .rsp_tag    (rsp_tag),
      .op_count   (op_count),
      .cc_zf      (cc_zf),
      .cc_sf      (cc_sf),
      .cc_of      (cc_of)
   );

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  tag;
      logic [63:0] res;
      logic        of;
   } vec_t;

   typedef struct {
      logic [63:0] res;
      logic        of;
      logic [3:0]  tag;
   } exp_t;

   exp_t        sb_q[$];
   logic        m_s1 = 1'b0;
   logic        m_s2 = 1'b0;
   logic        stall_prev = 1'b0;
   logic [63:0] prev_res;
   logic        prev_of;
   logic [3:0]  prev_tag;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                  input logic [3:0] tag);
      exp_t        e;
      logic [64:0] w;
      e.tag = tag;
      e.of  = 1'b0;
      case (op)
         2'b00: begin
            w = {a[63], a} + {b[63], b};
            e.res = w[63:0];
            e.of  = w[64] ^ w[63];
         end
         2'b01: begin
            w = {a[63], a} - {b[63], b};
            e.res = w[63:0];
            e.of  = w[64] ^ w[63];
         end
         2'b10:   e.res = a & b;
         default: e.res = a ^ b;
      endcase
      return e;
   endfunction

   // Holds reset for two edges, checks the cleared outputs and resets the bench model.
   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_of", rsp_of, 0);
      check("rst_rsp_tag", rsp_tag, 0);
      check("rst_op_count", op_count, 0);
      check("rst_cc", {cc_zf, cc_sf, cc_of}, 0);
      reset = 1'b0;
      #1;
      check("rst_req_ready", req_ready, 1);
      m_s1       = 1'b0;
      m_s2       = 1'b0;
      stall_prev = 1'b0;
      sb_q.delete();
   endtask

   // One clock of scoreboarded traffic; expected ready/valid come from a two-slot occupancy model.
   task automatic run_cycle(input logic v, input logic [1:0] op, input logic [63:0] a,
                            input logic [63:0] b, input logic [3:0] tag, input logic rr,
                            output logic acc);
      exp_t e;
      logic adv;
      req_valid  = v;
      req_opcode = op;
      req_a      = a;
      req_b      = b;
      req_tag    = tag;
      rsp_ready  = rr;
      #1;
      check("sb_req_ready", req_ready, !m_s1 || !m_s2 || rr);
      check("sb_rsp_valid", rsp_valid, m_s2);
      if (stall_prev) begin
         check("hold_result", rsp_result, prev_res);
         check("hold_of", rsp_of, prev_of);
         check("hold_tag", rsp_tag, prev_tag);
      end
      acc = v && req_ready;
      if (rsp_valid && rr) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_rsp", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("sb_result", rsp_result, e.res);
            check("sb_of", rsp_of, e.of);
            check("sb_tag", rsp_tag, e.tag);
         end
      end
      if (acc) sb_q.push_back(model(op, a, b, tag));
      stall_prev = rsp_valid && !rr;
      prev_res   = rsp_result;
      prev_of    = rsp_of;
      prev_tag   = rsp_tag;
      adv  = m_s1 && (!m_s2 || rr);
      m_s2 = adv || (m_s2 && !rr);
      m_s1 = acc || (m_s1 && !adv);
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[9];

   initial begin
      logic        acc;
      logic        saw_stall;
      logic [31:0] cnt_before;
      logic [63:0] ra;
      logic [63:0] rb;
      int          sent;
      int          cyc;
      int          n_acc;

      vecs[0] = '{2'b00, 64'd5, 64'd7, 4'd3, 64'd12, 1'b0};
      vecs[1] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd4, 64'h8000_0000_0000_0000, 1'b1};
      vecs[2] = '{2'b01, 64'd9, 64'd9, 4'd5, 64'd0, 1'b0};
      vecs[3] = '{2'b10, 64'hF0F0, 64'h0FF0, 4'd6, 64'h00F0, 1'b0};
      vecs[4] = '{2'b11, 64'hFF, 64'h0F, 4'd7, 64'hF0, 1'b0};
      vecs[5] = '{2'b01, 64'd0, 64'd1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      vecs[6] = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 4'd9, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
      vecs[7] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'hA, 64'd0, 1'b0};
      vecs[8] = '{2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'hF, 64'd0, 1'b1};

      do_reset();

      // Directed vectors, one at a time, checking latency and condition codes.
      for (int i = 0; i < 9; i++) begin
         req_valid  = 1'b1;
         req_opcode = vecs[i].op;
         req_a      = vecs[i].a;
         req_b      = vecs[i].b;
         req_tag    = vecs[i].tag;
         rsp_ready  = 1'b1;
         #1;
         check("vec_req_ready", req_ready, 1);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         check("vec_rsp_early", rsp_valid, 0);
         @(posedge clk);
         #1;
         check("vec_rsp_valid", rsp_valid, 1);
         check("vec_result", rsp_result, vecs[i].res);
         check("vec_of", rsp_of, vecs[i].of);
         check("vec_tag", rsp_tag, vecs[i].tag);
         @(posedge clk);
         #1;
         check("vec_rsp_done", rsp_valid, 0);
         check("vec_op_count", op_count, i + 1);
`ifdef ALU_ISSUE_CC_EN
         check("vec_cc", {cc_zf, cc_sf, cc_of},
               {(vecs[i].res == 64'd0), vecs[i].res[63], vecs[i].of});
`else
         check("vec_cc", {cc_zf, cc_sf, cc_of}, 0);
`endif
      end

      // Reset with two ops in flight: nothing stale may come out afterwards.
      run_cycle(1'b1, 2'b00, 64'd100, 64'd1, 4'd1, 1'b0, acc);
      run_cycle(1'b1, 2'b00, 64'd200, 64'd2, 4'd2, 1'b0, acc);
      check("pre_rst_full", req_ready, 0);
      do_reset();
      for (int i = 0; i < 3; i++) run_cycle(1'b0, 2'b00, '0, '0, '0, 1'b1, acc);

      // Backpressure: 8 ops with rsp_ready low for 4 cycles mid-stream.
      sent      = 0;
      cyc       = 0;
      saw_stall = 1'b0;
      while ((sent < 8 || sb_q.size() != 0 || m_s1 || m_s2) && cyc < 60) begin
         run_cycle(sent < 8, 2'b00, 64'(sent * 3), 64'd1, 4'(sent), !(cyc >= 3 && cyc < 7), acc);
         if (sent < 8 && !acc) saw_stall = 1'b1;
         if (acc) sent++;
         cyc++;
      end
      check("bp_all_sent", sent, 8);
      check("bp_drained", sb_q.size(), 0);
      check("bp_saw_not_ready", saw_stall, 1);
      check("bp_op_count", op_count, 8);

      // 100 back-to-back random ops with random response backpressure.
      do_reset();
      sent = 0;
      cyc  = 0;
      while ((sent < 100 || sb_q.size() != 0 || m_s1 || m_s2) && cyc < 3000) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if ($urandom_range(0, 7) == 0) ra = 64'h7FFF_FFFF_FFFF_FFFF;
         if ($urandom_range(0, 7) == 0) rb = 64'h8000_0000_0000_0000;
         run_cycle(sent < 100, 2'($urandom_range(0, 3)), ra, rb, 4'(sent),
                   $urandom_range(0, 3) != 0, acc);
         if (acc) sent++;
         cyc++;
      end
      check("rnd_all_sent", sent, 100);
      check("rnd_drained", sb_q.size(), 0);
      check("rnd_op_count", op_count, 100);

      // Full throughput: one op accepted every cycle while rsp_ready stays high.
      cnt_before = op_count;
      n_acc      = 0;
      for (int i = 0; i < 20; i++) begin
         run_cycle(1'b1, 2'b11, 64'(i), 64'hA5, 4'(i), 1'b1, acc);
         if (acc) n_acc++;
      end
      for (int i = 0; i < 3; i++) run_cycle(1'b0, 2'b00, '0, '0, '0, 1'b1, acc);
      check("tput_accepted", n_acc, 20);
      check("tput_op_count", op_count, cnt_before + 20);
      check("tput_drained", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
